// File: rtl/dmem_ctrl.sv
// Data-memory controller: single outstanding load/store with fixed wait-state latency
// into an internal byte-lane-writable word array.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic        ip_data_rd,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_dmem_rd,
    output logic        op_busy,
    output logic        op_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          commit;
    logic          mem_we;
    logic          oor;
    logic          acc_rd, acc_wr;
    logic [29:0]   acc_waddr;
    logic [3:0]    acc_mask;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;

    // Byte offset never selects a word; the processor extracts lanes itself.
    logic unused_byte_off;
    assign unused_byte_off = ^ip_data_addr[1:0];

    // With zero wait states the access happens on the accepting edge, so use live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_rd    = ip_data_rd;
            acc_wr    = ip_data_wr;
            acc_waddr = ip_data_addr[31:2];
            acc_mask  = ip_data_mask;
            acc_wdata = ip_data_from_proc;
        end else begin
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_waddr = waddr_q;
            acc_mask  = mask_q;
            acc_wdata = wdata_q;
        end
        acc_idx = acc_waddr[AW-1:0];
        oor     = acc_waddr >= 30'(DEPTH_WORDS);
    end

    // Next-state and response logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'd0;
        commit  = 1'b0;
        mem_we  = 1'b0;
        req     = ip_data_rd | ip_data_wr;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    waddr_d = ip_data_addr[31:2];
                    mask_d  = ip_data_mask;
                    wdata_d = ip_data_from_proc;
                    rd_d    = ip_data_rd;
                    wr_d    = ip_data_wr;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            valid_d = 1'b1;
            err_d   = oor | (acc_rd & acc_wr);
            mem_we  = acc_wr & ~acc_rd & ~oor;
            if (acc_rd && !acc_wr && !oor) begin
                rdata_d = mem[acc_idx];
            end
        end

        if (reset) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            valid_d = 1'b0;
            err_d   = 1'b0;
            rdata_d = 32'd0;
            mem_we  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        waddr_q <= waddr_d;
        mask_q  <= mask_d;
        wdata_q <= wdata_d;
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        valid_q <= valid_d;
        err_q   <= err_d;
        busy_q  <= busy_d;
        rdata_q <= rdata_d;
    end

    // Array is not reset; only enabled lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_mask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reset must silence the response in the same cycle it is asserted.
    assign op_data_valid      = valid_q & ~reset;
    assign op_err             = err_q & ~reset;
    assign op_busy            = busy_q & ~reset;
    assign op_data_to_dmem_rd = reset ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances (1, 0 and 3 wait states) with
// hand-computed expected latency, error and read data.
module tb_dmem_ctrl;

    logic clk;
    logic [2:0]       rst;
    logic [2:0]       rd_i, wr_i;
    logic [2:0][31:0] addr_i, wd_i;
    logic [2:0][3:0]  mask_i;
    logic [2:0]       vld_o, busy_o, err_o;
    logic [2:0][31:0] rdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst[0]), .ip_data_addr(addr_i[0]), .ip_data_wr(wr_i[0]),
        .ip_data_rd(rd_i[0]), .ip_data_mask(mask_i[0]), .ip_data_from_proc(wd_i[0]),
        .op_data_valid(vld_o[0]), .op_data_to_dmem_rd(rdata_o[0]),
        .op_busy(busy_o[0]), .op_err(err_o[0]));

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[1]), .ip_data_addr(addr_i[1]), .ip_data_wr(wr_i[1]),
        .ip_data_rd(rd_i[1]), .ip_data_mask(mask_i[1]), .ip_data_from_proc(wd_i[1]),
        .op_data_valid(vld_o[1]), .op_data_to_dmem_rd(rdata_o[1]),
        .op_busy(busy_o[1]), .op_err(err_o[1]));

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst[2]), .ip_data_addr(addr_i[2]), .ip_data_wr(wr_i[2]),
        .ip_data_rd(rd_i[2]), .ip_data_mask(mask_i[2]), .ip_data_from_proc(wd_i[2]),
        .op_data_valid(vld_o[2]), .op_data_to_dmem_rd(rdata_o[2]),
        .op_busy(busy_o[2]), .op_err(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE, ends at the negedge after the response pulse.
    task automatic txn(input int u, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d, input int exp_lat,
                       input logic exp_err, input logic [31:0] exp_data, input string tag);
        int          lat = 0;
        logic [31:0] gd  = 32'd0;
        logic        ge  = 1'b0;
        rd_i[u] = r; wr_i[u] = w; addr_i[u] = a; mask_i[u] = m; wd_i[u] = d;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd_i[u] = 1'b0;
                wr_i[u] = 1'b0;
            end
            if (vld_o[u]) begin
                lat = k;
                gd  = rdata_o[u];
                ge  = err_o[u];
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(ge), 32'(exp_err));
        check({tag, "_data"}, gd, exp_data);
        @(negedge clk);
        check({tag, "_pulse1"}, 32'(vld_o[u]), 32'd0);
    endtask

    initial begin
        int pulses;
        rst = 3'b111; rd_i = '0; wr_i = '0; addr_i = '0; wd_i = '0; mask_i = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_valid", 32'(vld_o[u]), 32'd0);
            check("rst_busy", 32'(busy_o[u]), 32'd0);
            check("rst_err", 32'(err_o[u]), 32'd0);
            check("rst_data", rdata_o[u], 32'd0);
        end
        rst = 3'b000;

        // One wait state: word store, byte-lane store, range and conflict errors.
        txn(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 2, 0, 32'h0, "wr10");
        txn(0, 1, 0, 32'h10, 4'hF, 32'h0, 2, 0, 32'hDEADBEEF, "rd10");
        txn(0, 0, 1, 32'h12, 4'b0100, 32'h00AA0000, 2, 0, 32'h0, "wr12_byte");
        txn(0, 1, 0, 32'h10, 4'hF, 32'h0, 2, 0, 32'hDEAABEEF, "rd10_byte");
        txn(0, 0, 1, 32'h0, 4'hF, 32'h11111111, 2, 0, 32'h0, "wr0");
        txn(0, 1, 0, 32'h1000, 4'hF, 32'h0, 2, 1, 32'h0, "rd_oor");
        txn(0, 0, 1, 32'h1000, 4'hF, 32'h12345678, 2, 1, 32'h0, "wr_oor");
        txn(0, 1, 0, 32'h0, 4'hF, 32'h0, 2, 0, 32'h11111111, "rd0_after_oor");
        txn(0, 0, 1, 32'hFFC, 4'hF, 32'h77777777, 2, 0, 32'h0, "wr_last");
        txn(0, 1, 0, 32'hFFC, 4'hF, 32'h0, 2, 0, 32'h77777777, "rd_last");
        txn(0, 0, 1, 32'h20, 4'hF, 32'hCAFEF00D, 2, 0, 32'h0, "wr20");
        txn(0, 1, 1, 32'h20, 4'hF, 32'h0, 2, 1, 32'h0, "rdwr20");
        txn(0, 1, 0, 32'h20, 4'hF, 32'h0, 2, 0, 32'hCAFEF00D, "rd20_after_rdwr");
        txn(0, 0, 1, 32'h20, 4'h0, 32'hFFFFFFFF, 2, 0, 32'h0, "wr20_mask0");
        txn(0, 1, 0, 32'h20, 4'hF, 32'h0, 2, 0, 32'hCAFEF00D, "rd20_after_mask0");

        // Reset during RESP: response suppressed, store already committed.
        wr_i[0] = 1'b1; addr_i[0] = 32'h30; mask_i[0] = 4'hF; wd_i[0] = 32'hA5A5A5A5;
        @(negedge clk); wr_i[0] = 1'b0;
        @(negedge clk);
        check("resp_rst_pre_valid", 32'(vld_o[0]), 32'd1);
        rst[0] = 1'b1;
        #1 check("resp_rst_valid", 32'(vld_o[0]), 32'd0);
        @(negedge clk); rst[0] = 1'b0;
        txn(0, 1, 0, 32'h30, 4'hF, 32'h0, 2, 0, 32'hA5A5A5A5, "rd30_after_resp_rst");

        // Zero wait states: back-to-back reads, request held through RESP.
        check("ws0_idle_busy", 32'(busy_o[1]), 32'd0);
        rd_i[1] = 1'b1; addr_i[1] = 32'h0;
        @(negedge clk);
        check("ws0_t1_valid", 32'(vld_o[1]), 32'd1);
        check("ws0_t1_busy", 32'(busy_o[1]), 32'd1);
        addr_i[1] = 32'h4;
        @(negedge clk);
        check("ws0_t2_valid", 32'(vld_o[1]), 32'd0);
        check("ws0_t2_busy", 32'(busy_o[1]), 32'd0);
        @(negedge clk);
        check("ws0_t3_valid", 32'(vld_o[1]), 32'd1);
        check("ws0_t3_busy", 32'(busy_o[1]), 32'd1);
        rd_i[1] = 1'b0;
        @(negedge clk);
        check("ws0_t4_valid", 32'(vld_o[1]), 32'd0);
        check("ws0_t4_busy", 32'(busy_o[1]), 32'd0);
        txn(1, 0, 1, 32'h8, 4'hF, 32'h5A5A5A5A, 1, 0, 32'h0, "ws0_wr8");
        txn(1, 1, 0, 32'h8, 4'hF, 32'h0, 1, 0, 32'h5A5A5A5A, "ws0_rd8");

        // Three wait states: reset in the second WAIT cycle drops the store.
        txn(2, 0, 1, 32'h40, 4'hF, 32'h01020304, 4, 0, 32'h0, "ws3_wr40");
        wr_i[2] = 1'b1; addr_i[2] = 32'h40; mask_i[2] = 4'hF; wd_i[2] = 32'hBBBBBBBB;
        @(negedge clk); wr_i[2] = 1'b0;
        check("ws3_wait1_busy", 32'(busy_o[2]), 32'd1);
        @(negedge clk);
        check("ws3_wait2_busy", 32'(busy_o[2]), 32'd1);
        rst[2] = 1'b1;
        #1 check("ws3_rst_busy", 32'(busy_o[2]), 32'd0);
        @(negedge clk); rst[2] = 1'b0;
        check("ws3_after_rst_busy", 32'(busy_o[2]), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (vld_o[2]) pulses++;
            @(negedge clk);
        end
        check("ws3_no_pulse", 32'(pulses), 32'd0);
        txn(2, 1, 0, 32'h40, 4'hF, 32'h0, 4, 0, 32'h01020304, "ws3_rd40_old");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data array (power of two, 16..65536).
REQ-002 Parameter WAIT_STATES, default 1, extra access cycles inserted before a response (0..15).
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset; synchronous, active-high.
REQ-005 Port ip_data_addr  input  32  byte address from processor.
REQ-006 Port ip_data_wr  input  1  store request.
REQ-007 Port ip_data_rd  input  1  load request.
REQ-008 Port ip_data_mask  input  4  byte-lane enables; bit n selects bits [8n+7:8n].
REQ-009 Port ip_data_from_proc  input  32  lane-aligned store data.
REQ-010 Port op_data_valid  output  1  one-cycle completion pulse for the accepted request.
REQ-011 Port op_data_to_dmem_rd  output  32  full read word; the processor performs lane extraction and sign extension.
REQ-012 Port op_busy  output  1  high whenever state is not IDLE.
REQ-013 Port op_err  output  1  error flag, meaningful only while op_data_valid is high.

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 IDLE: request = ip_data_rd | ip_data_wr; on request, latch addr, mask, store data and request type, then go to WAIT if WAIT_STATES>0, otherwise to RESP.
REQ-016 WAIT: load a 4-bit counter with WAIT_STATES on entry; decrement once per cycle; go to RESP on the cycle the counter reaches 1.
REQ-017 Inputs are ignored outside IDLE; only latched values are used.
REQ-018 Latency: a request sampled in IDLE at cycle T produces op_data_valid=1 in cycle T+1+WAIT_STATES, for exactly one cycle.
REQ-019 RESP always returns to IDLE next cycle; a request present in that IDLE cycle is treated as a new request (no deduplication).
REQ-020 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] is ignored for indexing.
REQ-021 Store: committed on the clock edge that enters RESP; only masked lanes are updated; mask 4'b0000 completes with no change and op_err=0.
REQ-022 Load: the array word is registered on the edge entering RESP and driven on op_data_to_dmem_rd during RESP.
REQ-023 op_data_to_dmem_rd = 0 outside RESP and for store responses.
REQ-024 Out of range: if addr[31:2] >= DEPTH_WORDS, the store is suppressed, the load returns 0, and op_err=1.
REQ-025 Simultaneous rd and wr: treated as an error; no store, data 0, op_err=1.
REQ-026 op_err = 0 whenever op_data_valid = 0.
REQ-027 Array contents are undefined at power-up and are not affected by reset.

Reset
REQ-028 While reset=1: state=IDLE, counter=0, op_data_valid=0, op_busy=0, op_err=0, op_data_to_dmem_rd=0.
REQ-029 Reset in WAIT: the pending store is discarded (no array change) and no response is issued.
REQ-030 Reset in RESP: op_data_valid is forced low that cycle; a store already committed on the edge entering RESP remains.
REQ-031 The first request is accepted in the first cycle after reset deasserts.

Verification
REQ-032 WAIT_STATES=1: wr addr 0x10, mask 4'b1111, data 0xDEADBEEF at T -> valid at T+2, err=0; rd addr 0x10 at T+3 -> valid at T+5, data 0xDEADBEEF.
REQ-033 Byte store: after REQ-032, wr addr 0x12, mask 4'b0100, data 0x00AA0000 -> subsequent rd 0x10 returns 0xDEAABEEF.
REQ-034 WAIT_STATES=0: back-to-back rd requests to 0x0 and 0x4 -> valid pulses at T+1 and T+3, busy high in T+1 and T+3 only.
REQ-035 DEPTH_WORDS=1024: rd addr 0x00001000 -> valid with err=1, data 0; wr to the same address leaves word 0 unchanged.
REQ-036 rd=wr=1 at addr 0x20 -> valid with err=1; the word at 0x20 is unchanged on read-back.
REQ-037 WAIT_STATES=3: wr issued, reset pulsed in the second WAIT cycle -> no valid pulse; read-back after reset shows the old value; busy=0 the cycle after reset.
